// File: rtl/button_event_classifier_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_classifier_if : debounced input / event output bus  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface button_event_classifier_if;
  logic db_level_i;
  logic db_tick_i;
  logic short_o;
  logic double_o;
  logic long_o;
  logic hold_o;
  logic busy_o;

  modport master (
    output db_level_i, db_tick_i,
    input  short_o, double_o, long_o, hold_o, busy_o
  );

  modport slave (
    input  db_level_i, db_tick_i,
    output short_o, double_o, long_o, hold_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/button_event_classifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_classifier : short / double / long press classifier |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module button_event_classifier #(
  parameter int unsigned LongCycles = 50_000_000,
  parameter int unsigned GapCycles  = 25_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  button_event_classifier_if.slave         bus
);

  localparam int unsigned MAX_CYCLES = (LongCycles > GapCycles) ? LongCycles : GapCycles;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LongCycles - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GapCycles - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.db_tick_i) state_d = PRESS1;
      end
      PRESS1: begin
        // Release has priority over the long threshold in the same cycle.
        if (!bus.db_level_i) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        // A second tick on the timeout cycle still counts as a double press.
        if (bus.db_tick_i) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!bus.db_level_i) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d  = LONG_HOLD;
          double_d = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!bus.db_level_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    hold_d = (state_d == LONG_HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.short_o  = short_q;
  assign bus.double_o = double_q;
  assign bus.long_o   = long_q;
  assign bus.hold_o   = hold_q;
  assign bus.busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_classifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_button_event_classifier : directed vector bench (L=20, G=10)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_button_event_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_event_classifier_if bus ();

  button_event_classifier #(
    .LongCycles (20),
    .GapCycles  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One step: hold inputs for n cycles (tick only on the first), then
  // expect the listed pulse counts over the step and final hold/busy levels.
  typedef struct {
    string nm;
    int    n;
    bit    lvl;
    bit    tick;
    int    e_short;
    int    e_double;
    int    e_long;
    bit    e_hold;
    bit    e_busy;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(string nm, int n, bit l, bit t, int s, int d, int lg, bit h, bit b);
    vec_t r;
    r.nm = nm; r.n = n; r.lvl = l; r.tick = t;
    r.e_short = s; r.e_double = d; r.e_long = lg; r.e_hold = h; r.e_busy = b;
    return r;
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    int cs, cd, cl;
    cs = 0; cd = 0; cl = 0;
    for (int i = 0; i < v.n; i++) begin
      bus.db_level_i = v.lvl;
      bus.db_tick_i  = (i == 0) ? v.tick : 1'b0;
      @(posedge clk);
      #1;
      cs += int'(bus.short_o);
      cd += int'(bus.double_o);
      cl += int'(bus.long_o);
      check({v.nm, ".excl"},
            int'(bus.short_o) + int'(bus.double_o) + int'(bus.long_o) <= 1, 1);
    end
    bus.db_tick_i = 1'b0;
    check({v.nm, ".short"},  cs, v.e_short);
    check({v.nm, ".double"}, cd, v.e_double);
    check({v.nm, ".long"},   cl, v.e_long);
    check({v.nm, ".hold"},   int'(bus.hold_o), int'(v.e_hold));
    check({v.nm, ".busy"},   int'(bus.busy_o), int'(v.e_busy));
  endtask

  task automatic check_all_zero(string nm);
    check({nm, ".short"},  int'(bus.short_o),  0);
    check({nm, ".double"}, int'(bus.double_o), 0);
    check({nm, ".long"},   int'(bus.long_o),   0);
    check({nm, ".hold"},   int'(bus.hold_o),   0);
    check({nm, ".busy"},   int'(bus.busy_o),   0);
  endtask

  // Assert reset between clock edges, check outputs clear at once, then
  // release reset with the given level still applied.
  task automatic mid_reset(string nm, bit lvl_after);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero(nm);
    bus.db_level_i = lvl_after;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.db_level_i = 1'b0;
    bus.db_tick_i  = 1'b0;

    //            name      n  lvl tick  s  d  l  hold busy
    // short press: release edge enters WAIT2, short on the 10th cycle after
    tbl.push_back(mk("sh.A",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh.B",   5, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh.C",   1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh.D",   9, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh.E",   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("sh.F",   1, 0, 0, 0, 0, 0, 0, 0));
    // double press
    tbl.push_back(mk("db.A",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.B",   4, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.C",   1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.D",   5, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.E",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.F",   3, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("db.G",   1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("db.H",  12, 0, 0, 0, 0, 0, 0, 0));
    // long press: long_o on the 20th edge after the tick edge
    tbl.push_back(mk("lg.A",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("lg.B",  19, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("lg.C",   1, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk("lg.D",  10, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("lg.E",   1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lg.F",  12, 0, 0, 0, 0, 0, 0, 0));
    // second tick on the WAIT2 timeout cycle
    tbl.push_back(mk("gt.A",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.B",   2, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.C",   1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.D",   9, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.E",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.F",   2, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gt.G",   1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("gt.H",  12, 0, 0, 0, 0, 0, 0, 0));
    // second tick one cycle too late: short, then an independent short
    tbl.push_back(mk("gl.A",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.B",   2, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.C",   1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.D",   9, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.E",   1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("gl.F",   1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.G",   2, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.H",   1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.I",   9, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gl.J",   1, 0, 0, 1, 0, 0, 0, 0));
    // second press held past the long threshold
    tbl.push_back(mk("sh2.A",  1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh2.B",  1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh2.C",  2, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh2.D",  1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh2.E", 19, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sh2.F",  1, 1, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk("sh2.G",  4, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("sh2.H",  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sh2.I",  5, 0, 0, 0, 0, 0, 0, 0));

    // reset state
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset during WAIT2: no short afterwards
    run_vec(mk("rw.A", 1, 1, 1, 0, 0, 0, 0, 1));
    run_vec(mk("rw.B", 2, 1, 0, 0, 0, 0, 0, 1));
    run_vec(mk("rw.C", 1, 0, 0, 0, 0, 0, 0, 1));
    run_vec(mk("rw.D", 3, 0, 0, 0, 0, 0, 0, 1));
    mid_reset("rw.rst", 1'b0);
    run_vec(mk("rw.E", 12, 0, 0, 0, 0, 0, 0, 0));

    // reset while pressed, level still held afterwards without a new tick
    run_vec(mk("rp.A", 1, 1, 1, 0, 0, 0, 0, 1));
    run_vec(mk("rp.B", 5, 1, 0, 0, 0, 0, 0, 1));
    mid_reset("rp.rst", 1'b1);
    run_vec(mk("rp.C", 25, 1, 0, 0, 0, 0, 0, 0));
    run_vec(mk("rp.D", 3, 0, 0, 0, 0, 0, 0, 0));

    // reset during LONG_HOLD drops hold_o at once
    run_vec(mk("rl.A", 1, 1, 1, 0, 0, 0, 0, 1));
    run_vec(mk("rl.B", 20, 1, 0, 0, 0, 1, 1, 1));
    mid_reset("rl.rst", 1'b1);
    run_vec(mk("rl.C", 5, 1, 0, 0, 0, 0, 0, 0));
    run_vec(mk("rl.D", 3, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
